multi_alarm_clock: RTL and testbench
====================================

// Module: multi_alarm_clock
// PURPOSE
//  Parametrised time-of-day core: BCD HH:MM:SS counter, ALARM_NUM programmable alarm slots, ring/snooze FSM.
//  Runs from the board clock; generates its own 1 Hz enable, so there are no derived clocks.
//  Outputs feed disp_decoder instances; ring and chime feed the tone stage.
// PARAMETERS
//  CLK_DIV     50_000_000  clk cycles per second tick (>=2)
//  ALARM_NUM   4           number of alarm slots (1..8)
//  RING_SEC    30          seconds an alarm rings before auto-stop (1..59)
//  SNOOZE_MIN  5           snooze length in minutes (1..9)
// PORTS
//  clk             in   1        board clock
//  clr_n           in   1        async active-low reset
//  min_inc         in   1        1-cycle pulse: minute +1, no carry into hours
//  hour_inc        in   1        1-cycle pulse: hour +1 (23->00)
//  alarm_wr        in   1        1-cycle pulse: write slot alarm_idx
//  alarm_idx       in   IW       slot index, IW=max(1,$clog2(ALARM_NUM))
//  alarm_hour_bcd  in   8        {tens,units} BCD hour 00..23
//  alarm_min_bcd   in   8        {tens,units} BCD minute 00..59
//  alarm_on        in   1        slot enable written with alarm_wr
//  ack             in   1        1-cycle pulse: stop ringing/cancel snooze
//  snooze          in   1        1-cycle pulse: defer current ring
//  sec_bcd/min_bcd/hour_bcd out 8 each  current time, BCD {tens,units}
//  tick_1hz        out  1        1-cycle pulse on each second increment
//  ring            out  1        alarm sounding
//  ring_idx        out  IW       slot that triggered the current ring/snooze
//  chime           out  1        hourly chime request (CHIME_EN only, else 0)
// BEHAVIOUR
//  - Reset: time 00:00:00, prescaler 0, all slots 00:00 disabled, FSM IDLE, every output 0.
//  - Prescaler counts 0..CLK_DIV-1; tick_1hz=1 in the cycle it wraps; registered time updates that same edge.
//  - Seconds 59->00 carries to minutes; minutes 59->00 with seconds carry increments hours; 23:59:59->00:00:00.
//  - min_inc/hour_inc act immediately; when coinciding with a carry into the same field, field advances by 1 only.
//  - min_inc at xx:59 wraps minutes to 00 without touching hours.
//  - alarm_wr: slot written only if both BCD fields valid (digits <=9, hour<=23, min<=59); invalid write ignored.
//  - alarm_idx >= ALARM_NUM: write ignored.
//  - Match: on a tick where the new time is HH:MM:00 equal to an enabled slot; lowest index wins ties.
//  - FSM IDLE: match -> RING, latch ring_idx, ring_cnt=0.
//  - FSM RING: ring=1; ring_cnt++ per tick; ack -> IDLE; snooze -> SNOOZE; ring_cnt==RING_SEC-1 at tick -> IDLE.
//  - FSM SNOOZE: ring=0; counts SNOOZE_MIN*60 ticks then -> RING (ring_cnt=0); ack -> IDLE.
//  - ack and snooze in same cycle: ack wins. Both ignored in IDLE.
//  - New matches while RING/SNOOZE are dropped; ring_idx holds until the next IDLE->RING.
//  - Time correction never retriggers or cancels an active RING/SNOOZE.
//  - Reset asserted mid-ring: ring drops asynchronously; state returns to IDLE.
//  - Latency: inputs registered on same edge; outputs are registers (no comb paths from inputs).
// CONFIGURATION
//  HOURLY_CHIME_EN defined: chime=1 during MM:SS 59:50..59:58 (even seconds) and 1 at 59:59 hour top;
//    independent of the FSM.
//  HOURLY_CHIME_EN undefined: no chime logic; chime tied 0.
// STRUCTURE
//  clock_pkg: BCD digit typedef, bcd_valid() helper, FSM state enum (IDLE/RING/SNOOZE), max-value constants.
//  Sub-module bcd_mod_counter (MOD, en, inc, Q_10/Q_01, cout) instantiated for sec, min, hour.
//  Alarm slots: register array + comparators + priority encoder inside top.
// TESTING (run with CLK_DIV=4)
//  1 Reset, 240 ticks -> time 00:04:00, tick_1hz every 4th cycle, ring=0.
//  2 Preload 23:59:58, 2 ticks -> 00:00:00; min_inc at 12:59 -> 12:00.
//  3 Slot2=00:01 on, slot0=00:01 on -> at 00:01:00 ring=1, ring_idx=0; auto-stop after RING_SEC ticks.
//  4 Ring, snooze -> ring=0 for 300 ticks, then ring=1; then ack -> ring=0, IDLE.
//  5 Write hour_bcd=8'h24 or min 8'h5A -> slot unchanged; ack+snooze same cycle -> IDLE.
//  6 HOURLY_CHIME_EN: 00:59:50..00:59:59 -> chime pattern as specified; undefined -> chime stays 0.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared types and helpers for the alarm clock core.
//  - bcd_t        : one BCD digit
//  - ring_state_e : alarm FSM states (IDLE / RING / SNOOZE)
//  - *_MOD/*_MAX  : counter moduli and largest legal field values
//  - bcd_valid()  : checks a {tens,units} BCD byte against an upper bound
package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } ring_state_e;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;
  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;

  // Wide enough for the longest snooze (9 min * 60 s).
  localparam int CNT_W = 10;

  function automatic logic bcd_valid(input logic [7:0] v, input int max_val);
    int dec;
    dec = int'(v[7:4]) * 10 + int'(v[3:0]);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (dec <= max_val);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter wrapping at MOD-1 -> 00.
//  clk, clr_n : clock, async active-low clear
//  en         : carry-in from the lower field (advance by one)
//  inc        : manual advance; coinciding with en still advances only once
//  q_10/q_01  : tens / units digit
//  cout       : carry-out, only from en at the top value (manual wrap never carries)
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic clk,
  input  logic clr_n,
  input  logic en,
  input  logic inc,
  output bcd_t q_10,
  output bcd_t q_01,
  output logic cout
);

  localparam bcd_t MAX_10 = 4'((MOD - 1) / 10);
  localparam bcd_t MAX_01 = 4'((MOD - 1) % 10);

  logic at_max;
  assign at_max = (q_10 == MAX_10) && (q_01 == MAX_01);
  assign cout   = en & at_max;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_10 <= '0;
      q_01 <= '0;
    end else if (en || inc) begin
      if (at_max) begin
        q_10 <= '0;
        q_01 <= '0;
      end else if (q_01 == 4'd9) begin
        q_10 <= q_10 + 4'd1;
        q_01 <= '0;
      end else begin
        q_01 <= q_01 + 4'd1;
      end
    end
  end

endmodule

// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: BCD HH:MM:SS time-of-day core with ALARM_NUM alarm slots
// and a ring/snooze FSM. Runs from the board clock with an internal 1 Hz enable.
//  clk, clr_n                  : board clock, async active-low reset
//  min_inc / hour_inc          : manual time correction pulses
//  alarm_wr/idx/hour/min/on    : slot write (ignored if BCD invalid or idx out of range)
//  ack / snooze                : stop ringing / defer ring (ack wins)
//  sec_bcd/min_bcd/hour_bcd    : current time, BCD {tens,units}
//  tick_1hz                    : pulse coinciding with each new second value
//  ring / ring_idx             : alarm sounding, slot that started it
//  chime                       : hourly chime request
// Optional feature: define HOURLY_CHIME_EN to build the chime logic; otherwise
// chime is tied low.
module multi_alarm_clock
  import clock_pkg::*;
#(
  parameter int CLK_DIV    = 50_000_000,
  parameter int ALARM_NUM  = 4,
  parameter int RING_SEC   = 30,
  parameter int SNOOZE_MIN = 5,
  localparam int IW = (ALARM_NUM > 1) ? $clog2(ALARM_NUM) : 1
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          min_inc,
  input  logic          hour_inc,
  input  logic          alarm_wr,
  input  logic [IW-1:0] alarm_idx,
  input  logic [7:0]    alarm_hour_bcd,
  input  logic [7:0]    alarm_min_bcd,
  input  logic          alarm_on,
  input  logic          ack,
  input  logic          snooze,
  output logic [7:0]    sec_bcd,
  output logic [7:0]    min_bcd,
  output logic [7:0]    hour_bcd,
  output logic          tick_1hz,
  output logic          ring,
  output logic [IW-1:0] ring_idx,
  output logic          chime
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SEC - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_MIN * 60 - 1);

  // Prescaler; the wrap cycle advances the time and raises tick_1hz together.
  logic [PW-1:0] presc;
  logic          wrap;
  assign wrap = (presc == PW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      presc    <= '0;
      tick_1hz <= 1'b0;
    end else begin
      presc    <= wrap ? '0 : presc + 1'b1;
      tick_1hz <= wrap;
    end
  end

  logic sec_cout, min_cout, unused_day_wrap;

  bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
    .clk(clk), .clr_n(clr_n), .en(wrap), .inc(1'b0),
    .q_10(sec_bcd[7:4]), .q_01(sec_bcd[3:0]), .cout(sec_cout)
  );
  bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
    .clk(clk), .clr_n(clr_n), .en(sec_cout), .inc(min_inc),
    .q_10(min_bcd[7:4]), .q_01(min_bcd[3:0]), .cout(min_cout)
  );
  bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
    .clk(clk), .clr_n(clr_n), .en(min_cout), .inc(hour_inc),
    .q_10(hour_bcd[7:4]), .q_01(hour_bcd[3:0]), .cout(unused_day_wrap)
  );

  // Alarm slots. Out-of-range indices simply match no slot.
  logic [ALARM_NUM-1:0][7:0] slot_hour, slot_min;
  logic [ALARM_NUM-1:0]      slot_en;
  logic                      wr_ok;
  assign wr_ok = alarm_wr && bcd_valid(alarm_hour_bcd, HOUR_MAX)
                          && bcd_valid(alarm_min_bcd, MIN_MAX);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      slot_hour <= '0;
      slot_min  <= '0;
      slot_en   <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < ALARM_NUM; i++) begin
        if (alarm_idx == IW'(i)) begin
          slot_hour[i] <= alarm_hour_bcd;
          slot_min[i]  <= alarm_min_bcd;
          slot_en[i]   <= alarm_on;
        end
      end
    end
  end

  // Priority encoder: scanning downward lets the lowest matching index win.
  // Evaluated in the tick_1hz cycle so it sees the freshly updated time.
  logic          hit;
  logic [IW-1:0] hit_idx;
  logic          match;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = ALARM_NUM - 1; i >= 0; i--) begin
      if (slot_en[i] && slot_hour[i] == hour_bcd && slot_min[i] == min_bcd) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign match = tick_1hz && (sec_bcd == 8'h00) && hit;

  // Ring/snooze FSM; one counter serves both ring length and snooze length.
  ring_state_e      state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [IW-1:0]    idx_next;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ring_idx <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      ring_idx <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = ring_idx;
    case (state)
      ST_IDLE: begin
        if (match) begin
          state_next = ST_RING;
          cnt_next   = '0;
          idx_next   = hit_idx;
        end
      end
      ST_RING: begin
        if (ack) begin
          state_next = ST_IDLE;
        end else if (snooze) begin
          state_next = ST_SNOOZE;
          cnt_next   = '0;
        end else if (tick_1hz) begin
          if (cnt == RING_LAST) state_next = ST_IDLE;
          else                  cnt_next   = cnt + 1'b1;
        end
      end
      ST_SNOOZE: begin
        if (ack) begin
          state_next = ST_IDLE;
        end else if (tick_1hz) begin
          if (cnt == SNOOZE_LAST) begin
            state_next = ST_RING;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ring = (state == ST_RING);
  end

`ifdef HOURLY_CHIME_EN
  // Pips on even seconds 50..58, long tone on :59.
  always_comb begin
    chime = (min_bcd == 8'h59) && (sec_bcd[7:4] == 4'd5) &&
            ((sec_bcd[3:0] == 4'd9) || !sec_bcd[0]);
  end
`else
  assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_multi_alarm_clock.sv
module tb_multi_alarm_clock;

  localparam int CLK_DIV = 4, ALARM_NUM = 3, RING_SEC = 30, SNOOZE_MIN = 5, IW = 2;
  localparam int M_IDLE = 0, M_RING = 1, M_SNZ = 2;

  logic clk = 1'b0, clr_n = 1'b0;
  logic min_inc = 0, hour_inc = 0, alarm_wr = 0, alarm_on = 0, ack = 0, snooze = 0;
  logic [IW-1:0] alarm_idx = '0;
  logic [7:0] alarm_hour_bcd = 8'h00, alarm_min_bcd = 8'h00;
  logic [7:0] sec_bcd, min_bcd, hour_bcd;
  logic tick_1hz, ring, chime;
  logic [IW-1:0] ring_idx;

  always #5 clk = ~clk;

  multi_alarm_clock #(.CLK_DIV(CLK_DIV), .ALARM_NUM(ALARM_NUM), .RING_SEC(RING_SEC),
                      .SNOOZE_MIN(SNOOZE_MIN)) dut (
    .clk(clk), .clr_n(clr_n), .min_inc(min_inc), .hour_inc(hour_inc),
    .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_hour_bcd(alarm_hour_bcd),
    .alarm_min_bcd(alarm_min_bcd), .alarm_on(alarm_on), .ack(ack), .snooze(snooze),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd), .tick_1hz(tick_1hz),
    .ring(ring), .ring_idx(ring_idx), .chime(chime)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  // ---------------- behavioural model (decimal time, tick counting) ----------
  int m_presc = 0, m_h = 0, m_m = 0, m_s = 0, m_tick = 0;
  int m_state = M_IDLE, m_cnt = 0, m_idx = 0, m_hit;
  int sl_h[ALARM_NUM], sl_m[ALARM_NUM];
  bit sl_en[ALARM_NUM];
  bit tk, cs, cm;

  function automatic bit valid(input logic [7:0] v, input int mx);
    int d;
    d = int'(v[7:4]) * 10 + int'(v[3:0]);
    return (v[7:4] <= 9) && (v[3:0] <= 9) && (d <= mx);
  endfunction

  function automatic int dec(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic int to_bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_presc = 0; m_h = 0; m_m = 0; m_s = 0; m_tick = 0;
      m_state = M_IDLE; m_cnt = 0; m_idx = 0;
      for (int i = 0; i < ALARM_NUM; i++) begin
        sl_h[i] = 0; sl_m[i] = 0; sl_en[i] = 0;
      end
    end else begin
      // Alarm decision uses the time shown during the tick cycle.
      m_hit = -1;
      if (m_tick != 0 && m_s == 0)
        for (int i = ALARM_NUM - 1; i >= 0; i--)
          if (sl_en[i] && sl_h[i] == m_h && sl_m[i] == m_m) m_hit = i;
      case (m_state)
        M_IDLE: if (m_hit >= 0) begin m_state = M_RING; m_cnt = 0; m_idx = m_hit; end
        M_RING: begin
          if (ack) m_state = M_IDLE;
          else if (snooze) begin m_state = M_SNZ; m_cnt = 0; end
          else if (m_tick != 0) begin
            m_cnt++;
            if (m_cnt == RING_SEC) m_state = M_IDLE;
          end
        end
        default: begin
          if (ack) m_state = M_IDLE;
          else if (m_tick != 0) begin
            m_cnt++;
            if (m_cnt == SNOOZE_MIN * 60) begin m_state = M_RING; m_cnt = 0; end
          end
        end
      endcase
      tk = (m_presc == CLK_DIV - 1);
      m_presc = tk ? 0 : m_presc + 1;
      cs = tk && m_s == 59;
      if (tk) m_s = (m_s + 1) % 60;
      cm = cs && m_m == 59;
      if (cs || min_inc) m_m = (m_m + 1) % 60;
      if (cm || hour_inc) m_h = (m_h + 1) % 24;
      if (alarm_wr && int'(alarm_idx) < ALARM_NUM && valid(alarm_hour_bcd, 23) &&
          valid(alarm_min_bcd, 59)) begin
        sl_h[alarm_idx]  = dec(alarm_hour_bcd);
        sl_m[alarm_idx]  = dec(alarm_min_bcd);
        sl_en[alarm_idx] = alarm_on;
      end
      m_tick = tk ? 1 : 0;
    end
  end

  function automatic int m_chime();
`ifdef HOURLY_CHIME_EN
    return (m_m == 59 && ((m_s >= 50 && m_s <= 58 && m_s % 2 == 0) || m_s == 59)) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin
    chk("sec", sec_bcd, to_bcd(m_s));
    chk("min", min_bcd, to_bcd(m_m));
    chk("hour", hour_bcd, to_bcd(m_h));
    chk("tick", tick_1hz, m_tick);
    chk("ring", ring, (m_state == M_RING) ? 1 : 0);
    chk("ring_idx", ring_idx, m_idx);
    chk("chime", chime, m_chime());
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #2 clr_n = 1'b0;
    cyc(2);
    #2 clr_n = 1'b1;
    cyc(1);
  endtask

  task automatic pulse_min(input int n);
    min_inc = 1'b1; cyc(n); min_inc = 1'b0;
  endtask

  task automatic pulse_hour(input int n);
    hour_inc = 1'b1; cyc(n); hour_inc = 1'b0;
  endtask

  task automatic write_slot(input int idx, input logic [7:0] h, input logic [7:0] m,
                            input logic on);
    alarm_idx = IW'(idx); alarm_hour_bcd = h; alarm_min_bcd = m; alarm_on = on;
    alarm_wr = 1'b1; cyc(1); alarm_wr = 1'b0;
  endtask

  task automatic press(input logic a, input logic s);
    ack = a; snooze = s; cyc(1); ack = 1'b0; snooze = 1'b0;
  endtask

  task automatic wait_sec(input logic [7:0] v, input int budget, input string nm);
    int n = 0;
    while (sec_bcd !== v && n < budget) begin cyc(1); n++; end
    if (sec_bcd !== v) timeout(nm);
  endtask

  task automatic wait_tick(input string nm);
    int n = 0;
    do begin cyc(1); n++; end while (tick_1hz !== 1'b1 && n < 2 * CLK_DIV);
    if (tick_1hz !== 1'b1) timeout(nm);
  endtask

  // Returns the number of cycles until ring reaches lvl.
  task automatic wait_ring(input logic lvl, input int budget, input string nm,
                           output int n);
    n = 0;
    while (ring !== lvl && n < budget) begin cyc(1); n++; end
    if (ring !== lvl) timeout(nm);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt_t, ring_hi;
    logic [10:0] got_pat, exp_pat;

    cyc(3);
    clr_n = 1'b1;
    // 1: reset state and 240 seconds of free running
    chk("rst_sec", sec_bcd, 0);
    chk("rst_ring", ring, 0);
    chk("rst_tick", tick_1hz, 0);
    cnt_t = 0;
    repeat (240 * CLK_DIV) begin cyc(1); if (tick_1hz) cnt_t++; end
    chk("t1_ticks", cnt_t, 240);
    chk("t1_min", min_bcd, 8'h04);
    chk("t1_sec", sec_bcd, 8'h00);
    chk("t1_hour", hour_bcd, 8'h00);

    // 2: midnight rollover and manual minute wrap without hour carry
    do_reset();
    pulse_hour(23);
    pulse_min(59);
    wait_sec(8'h58, 61 * CLK_DIV, "t2_wait58");
    wait_tick("t2_tick1");
    wait_tick("t2_tick2");
    chk("t2_hour", hour_bcd, 8'h00);
    chk("t2_min", min_bcd, 8'h00);
    chk("t2_sec", sec_bcd, 8'h00);
    pulse_hour(12);
    pulse_min(59);
    chk("t2_min59", min_bcd, 8'h59);
    pulse_min(1);
    chk("t2_minwrap", min_bcd, 8'h00);
    chk("t2_hourkeep", hour_bcd, 8'h12);

    // 3: two slots on the same minute, lowest index wins, auto-stop
    do_reset();
    write_slot(2, 8'h00, 8'h01, 1'b1);
    write_slot(0, 8'h00, 8'h01, 1'b1);
    wait_ring(1'b1, 70 * CLK_DIV, "t3_ring", n);
    chk("t3_idx", ring_idx, 0);
    chk("t3_min", min_bcd, 8'h01);
    chk("t3_sec", sec_bcd, 8'h00);
    wait_ring(1'b0, (RING_SEC + 5) * CLK_DIV, "t3_stop", ring_hi);
    chk("t3_ring_len", ring_hi, RING_SEC * CLK_DIV);

    // 4: snooze defers for 300 s (a match inside the snooze is dropped), then ack
    write_slot(1, 8'h00, 8'h02, 1'b1);
    write_slot(2, 8'h00, 8'h04, 1'b1);
    wait_ring(1'b1, 40 * CLK_DIV, "t4_ring", n);
    chk("t4_idx", ring_idx, 1);
    cyc(3);
    press(1'b0, 1'b1);
    chk("t4_snz_low", ring, 0);
    wait_ring(1'b1, 320 * CLK_DIV, "t4_rering", n);
    chk("t4_snz_len", (n >= 1197 && n <= 1200) ? 1 : 0, 1);
    chk("t4_idx_hold", ring_idx, 1);
    cyc(2);
    press(1'b1, 1'b0);
    chk("t4_ack", ring, 0);
    cyc(40);
    chk("t4_idle", ring, 0);

    // 5: invalid and out-of-range writes ignored; ack+snooze together -> idle
    write_slot(2, 8'h00, 8'h09, 1'b1);
    write_slot(2, 8'h24, 8'h09, 1'b0);
    write_slot(2, 8'h00, 8'h5A, 1'b0);
    write_slot(3, 8'h00, 8'h08, 1'b1);
    wait_ring(1'b1, 200 * CLK_DIV, "t5_ring", n);
    chk("t5_idx", ring_idx, 2);
    chk("t5_min", min_bcd, 8'h09);
    cyc(2);
    press(1'b1, 1'b1);
    chk("t5_both", ring, 0);
    ring_hi = 0;
    repeat (310 * CLK_DIV) begin cyc(1); if (ring) ring_hi++; end
    chk("t5_stay_idle", ring_hi, 0);

    // Reset asserted while ringing drops ring immediately
    write_slot(0, 8'h00, 8'h15, 1'b1);
    wait_ring(1'b1, 70 * CLK_DIV, "t5r_ring", n);
    cyc(2);
    #2 clr_n = 1'b0;
    #1;
    chk("rst_mid_ring", ring, 0);
    chk("rst_mid_min", min_bcd, 0);
    cyc(2);
    #2 clr_n = 1'b1;
    cyc(1);

    // 6: hourly chime window 00:59:50 .. 01:00:00
    pulse_min(59);
    wait_sec(8'h49, 61 * CLK_DIV, "t6_wait49");
    got_pat = '0;
    for (int i = 0; i < 11; i++) begin
      wait_tick("t6_tick");
      got_pat[i] = chime;
    end
`ifdef HOURLY_CHIME_EN
    exp_pat = 11'b01101010101;
`else
    exp_pat = 11'b00000000000;
`endif
    chk("t6_chime_pat", got_pat, exp_pat);
    chk("t6_hour", hour_bcd, 8'h01);
    chk("t6_min", min_bcd, 8'h00);

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
